// File: rtl/hack_mem_sequencer.sv
// Shares one single-port synchronous RAM between the single-cycle Hack CPU and a video reader.
// Each instruction is fetch, operand load, then execute; bounded video bursts run between instructions.
module hack_mem_sequencer #(
    parameter int          AW            = 15,
    parameter int          DW            = 16,
    parameter int          VID_MAX_BURST = 4,
    parameter logic [15:0] INSTRET_INIT  = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   cpu_inst_addr,
    input  logic [15:0]   cpu_data_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_inst,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ce,
    output logic [15:0]   instret,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    dbg_state
);

    // Video handshake: vid_req is a level request; vid_ack marks the cycle vid_addr is
    // taken, and vid_valid/vid_rdata carry that word exactly one cycle later.
    localparam int CW = $clog2(VID_MAX_BURST + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LOAD_I = 3'd1,
        LOAD_D = 3'd2,
        EXEC   = 3'd3,
        VIDEO  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] vid_cnt;
    logic          last_grant;

    assign last_grant = (vid_cnt == CW'(VID_MAX_BURST - 1));
    assign mem_wdata  = cpu_wdata;
    assign vid_rdata  = mem_rdata;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   state_next = LOAD_I;
            LOAD_I:  state_next = LOAD_D;
            LOAD_D:  state_next = EXEC;
            EXEC:    state_next = vid_req ? VIDEO : FETCH;
            VIDEO: begin
                if (!vid_req || last_grant) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Strobes are masked by rst so a reset mid-instruction never writes or retires.
    always_comb begin
        mem_addr = cpu_inst_addr[AW-1:0];
        mem_we   = 1'b0;
        cpu_ce   = 1'b0;
        vid_ack  = 1'b0;
        case (state)
            FETCH:   mem_addr = cpu_inst_addr[AW-1:0];
            LOAD_I,
            LOAD_D:  mem_addr = cpu_data_addr[AW-1:0];
            EXEC: begin
                mem_addr = cpu_data_addr[AW-1:0];
                mem_we   = cpu_we & ~rst;
                cpu_ce   = ~rst;
            end
            VIDEO: begin
                mem_addr = vid_addr;
                vid_ack  = vid_req & ~rst;
            end
            default: mem_addr = cpu_inst_addr[AW-1:0];
        endcase
    end

    // RAM data arrives one cycle after its address, so each latch happens one state later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_inst  <= '0;
            cpu_rdata <= '0;
            instret   <= INSTRET_INIT;
            vid_cnt   <= '0;
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= vid_ack;
            if (state == LOAD_I) begin
                cpu_inst <= mem_rdata;
            end
            if (state == LOAD_D) begin
                cpu_rdata <= mem_rdata;
            end
            if (cpu_ce) begin
                instret <= instret + 16'd1;
                vid_cnt <= '0;
            end else if (vid_ack) begin
                vid_cnt <= vid_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hack_mem_sequencer.sv
// Directed bench for hack_mem_sequencer: RAM model, per-cycle video data scoreboard,
// and a second instance started near the instret wrap point.
module tb_hack_mem_sequencer;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_VIDEO = 3'd4;

    logic          clk;
    logic          rst;
    logic [15:0]   cpu_inst_addr;
    logic [15:0]   cpu_data_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic [DW-1:0] cpu_inst;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ce;
    logic [15:0]   instret;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_valid;
    logic [DW-1:0] vid_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    dbg_state;

    logic [DW-1:0] w_cpu_inst;
    logic [DW-1:0] w_cpu_rdata;
    logic          w_cpu_ce;
    logic [15:0]   w_instret;
    logic          w_vid_req;
    logic [AW-1:0] w_vid_addr;
    logic          w_vid_ack;
    logic          w_vid_valid;
    logic [DW-1:0] w_vid_rdata;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_mem_we;
    logic [DW-1:0] w_mem_rdata;
    logic [2:0]    w_dbg_state;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          ram_ready = 1'b0;

    int            total  = 0;
    int            passed = 0;
    int            we_cnt = 0;
    int            ack_cnt = 0;
    int            vv_err = 0;
    int            vr_err = 0;
    logic          prev_ack = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            n;

    hack_mem_sequencer #(.AW(AW), .DW(DW), .VID_MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_inst_addr(cpu_inst_addr), .cpu_data_addr(cpu_data_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_inst(cpu_inst), .cpu_rdata(cpu_rdata), .cpu_ce(cpu_ce), .instret(instret),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_rdata(vid_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    hack_mem_sequencer #(.AW(AW), .DW(DW), .VID_MAX_BURST(4), .INSTRET_INIT(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst),
        .cpu_inst_addr(cpu_inst_addr), .cpu_data_addr(cpu_data_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(1'b0),
        .cpu_inst(w_cpu_inst), .cpu_rdata(w_cpu_rdata), .cpu_ce(w_cpu_ce), .instret(w_instret),
        .vid_req(w_vid_req), .vid_addr(w_vid_addr), .vid_ack(w_vid_ack),
        .vid_valid(w_vid_valid), .vid_rdata(w_vid_rdata),
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_we(w_mem_we), .mem_rdata(w_mem_rdata),
        .dbg_state(w_dbg_state)
    );

    assign w_vid_req   = 1'b0;
    assign w_vid_addr  = '0;
    assign w_mem_rdata = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    // single-port synchronous RAM, preloaded on the first edge
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
            ram[15'h0000] <= 16'h0005;
            ram[15'h0005] <= 16'h1234;
            ram[15'h0020] <= 16'h7777;
            ram[15'h0100] <= 16'hCAFE;
            ram[15'h0101] <= 16'hF00D;
            ram_ready     <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // one clock: sample this cycle's strobes just before the edge, return at the next negedge
    task automatic step();
        logic [DW-1:0] w;
        #1;
        if (mem_we === 1'b1) we_cnt++;
        if (vid_ack === 1'b1) ack_cnt++;
        if (vid_valid !== prev_ack) vv_err++;
        if (vid_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vr_err++;
            end else begin
                w = exp_q.pop_front();
                if (vid_rdata !== w) vr_err++;
            end
        end
        if (vid_ack === 1'b1) exp_q.push_back(ram[vid_addr]);
        prev_ack = vid_ack;
        @(negedge clk);
    endtask

    task automatic wait_ce(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (cpu_ce !== 1'b1 && cycles < 40);
    endtask

    initial begin
        rst = 1'b1;
        cpu_inst_addr = 16'h0000;
        cpu_data_addr = 16'h0000;
        cpu_wdata = 16'h0000;
        cpu_we = 1'b0;
        vid_req = 1'b0;
        vid_addr = 15'h0100;

        // reset state
        @(negedge clk);
        chk("rst_ce", cpu_ce, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_inst", cpu_inst, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_instret", instret, 0);
        chk("rst_vvalid", vid_valid, 0);
        chk("rst_state", dbg_state, S_FETCH);
        chk("rst_instret_w", w_instret, 16'hFFFE);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("fetch_addr", mem_addr, 15'h0000);

        // basic fetch/load/exec, 4-cycle period
        wait_ce(n);
        chk("t1_first_ce", n, 3);
        chk("t1_state", dbg_state, S_EXEC);
        chk("t1_inst", cpu_inst, 16'h0005);
        chk("t1_rdata", cpu_rdata, 16'h0005);
        chk("t1_instret", instret, 0);
        cpu_data_addr = 16'h0005;
        wait_ce(n);
        chk("t1_period", n, 4);
        chk("t1_rdata2", cpu_rdata, 16'h1234);
        chk("t1_instret2", instret, 1);

        // write in EXEC, upper address bit truncated
        we_cnt = 0;
        cpu_data_addr = 16'h8010;
        cpu_we = 1'b1;
        cpu_wdata = 16'hBEEF;
        #1;
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 15'h0010);
        chk("t2_wdata", mem_wdata, 16'hBEEF);
        step();
        cpu_we = 1'b1;
        #1;
        chk("t2_we_fetch", mem_we, 0);
        cpu_we = 1'b0;
        wait_ce(n);
        chk("t2_period", n, 3);
        chk("t2_rdata", cpu_rdata, 16'hBEEF);
        chk("t2_ram10", ram[15'h0010], 16'hBEEF);
        chk("t2_ram5", ram[15'h0005], 16'h1234);
        chk("t2_instret", instret, 2);

        // video held high: full bursts of 4, period 8
        cpu_data_addr = 16'h0005;
        vid_req = 1'b1;
        ack_cnt = 0;
        wait_ce(n);
        chk("t3_period", n, 8);
        chk("t3_acks", ack_cnt, 4);
        chk("t3_inst", cpu_inst, 16'h0005);
        chk("t3_rdata", cpu_rdata, 16'h1234);
        vid_addr = 15'h0101;
        ack_cnt = 0;
        wait_ce(n);
        chk("t3_period2", n, 8);
        chk("t3_acks2", ack_cnt, 4);
        chk("t3_inst2", cpu_inst, 16'h0005);

        // video dropped after two grants
        ack_cnt = 0;
        step();
        step();
        step();
        vid_req = 1'b0;
        #1;
        chk("t4_noack", vid_ack, 0);
        chk("t4_state", dbg_state, S_VIDEO);
        wait_ce(n);
        chk("t4_period", n + 3, 7);
        chk("t4_acks", ack_cnt, 2);
        chk("t4_rdata", cpu_rdata, 16'h1234);

        // request raised in LOAD_I waits until after EXEC
        step();
        step();
        vid_req = 1'b1;
        #1;
        chk("t4b_noack", vid_ack, 0);
        chk("t4b_addr", mem_addr, 15'h0005);
        ack_cnt = 0;
        wait_ce(n);
        chk("t4b_period", n, 2);
        chk("t4b_acks", ack_cnt, 0);
        chk("t4b_instret", instret, 6);

        // reset in EXEC with a pending write
        cpu_we = 1'b1;
        cpu_data_addr = 16'h0020;
        cpu_wdata = 16'hDEAD;
        rst = 1'b1;
        #1;
        chk("t5_we", mem_we, 0);
        chk("t5_ce", cpu_ce, 0);
        chk("t5_ack", vid_ack, 0);
        step();
        chk("t5_instret", instret, 0);
        chk("t5_state", dbg_state, S_FETCH);
        chk("t5_inst", cpu_inst, 0);
        chk("t5_rdata", cpu_rdata, 0);
        chk("t5_ram20", ram[15'h0020], 16'h7777);
        chk("t5_instret_w", w_instret, 16'hFFFE);
        rst = 1'b0;
        cpu_we = 1'b0;
        cpu_data_addr = 16'h0005;
        ack_cnt = 0;
        wait_ce(n);
        chk("t5_period", n, 3);
        chk("t5_acks", ack_cnt, 0);
        chk("t5_instret0", instret, 0);
        chk("t5_inst2", cpu_inst, 16'h0005);
        chk("t5_w_ce", w_cpu_ce, 1);
        step();
        chk("t5_instret1", instret, 1);
        chk("t5_w_ffff", w_instret, 16'hFFFF);
        chk("t5_vstate", dbg_state, S_VIDEO);

        // reset in VIDEO clears the pending vid_valid
        step();
        chk("t5_vvalid", vid_valid, 1);
        chk("t5_vrdata", vid_rdata, 16'hF00D);
        rst = 1'b1;
        #1;
        chk("t5_vack_rst", vid_ack, 0);
        step();
        chk("t5_vvalid_clr", vid_valid, 0);
        chk("t5_vstate_rst", dbg_state, S_FETCH);
        rst = 1'b0;
        vid_req = 1'b0;

        // instret wrap on the preloaded instance
        wait_ce(n);
        chk("t6_period", n, 3);
        chk("t6_w_fffe", w_instret, 16'hFFFE);
        step();
        chk("t6_w_ffff", w_instret, 16'hFFFF);
        wait_ce(n);
        chk("t6_period2", n, 3);
        chk("t6_w_ce", w_cpu_ce, 1);
        step();
        chk("t6_w_wrap", w_instret, 16'h0000);
        chk("t6_instret", instret, 2);

        // scoreboard totals
        chk("total_writes", we_cnt, 1);
        chk("vid_valid_follow", vv_err, 0);
        chk("vid_rdata_match", vr_err, 0);
        chk("vid_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
